// File: rtl/laser_pkg.sv
// Shared types for the laser shot sequencer and the per-quadrant display layers.
package laser_pkg;

    localparam int LASER_R_W = 4;

    typedef logic [1:0] quadrant_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXTEND   = 2'd1,
        HOLD     = 2'd2,
        COOLDOWN = 2'd3
    } laser_state_t;

endpackage

// File: rtl/laser_frame_timer.sv
// Frame-tick counter: hit fires on the tick that brings the count to target,
// and the count restarts from zero on that same tick.
module laser_frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       clear,
    input  logic [7:0] target,
    output logic       hit
);

    logic [7:0] fcnt_q;
    logic [7:0] fcnt_d;

    // Next count and terminal-tick detection; clear wins over a same-cycle tick.
    always_comb begin
        hit    = 1'b0;
        fcnt_d = fcnt_q;
        if (clear) begin
            fcnt_d = 8'd0;
        end else if (frame_tick) begin
            if (fcnt_q == (target - 8'd1)) begin
                hit    = 1'b1;
                fcnt_d = 8'd0;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= 8'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

endmodule

// File: rtl/laser_controller.sv
// Laser shot sequencer: fire -> extend beam one radius step per STEP_FRAMES
// ticks -> hold at R_MAX -> report shot -> cooldown before the next fire.
module laser_controller
    import laser_pkg::*;
#(
    parameter int unsigned STEP_FRAMES     = 2,
    parameter int unsigned HOLD_FRAMES     = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned R_MAX           = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [1:0] aim_quadrant,
    input  logic       abort,
    output logic       laser_active,
    output logic [3:0] laser_r,
    output logic [1:0] laser_quadrant,
    output logic       busy,
    output logic       shot_done,
    output logic [1:0] shot_quadrant
);

    localparam logic [7:0]           STEP_T = 8'(STEP_FRAMES);
    localparam logic [7:0]           HOLD_T = 8'(HOLD_FRAMES);
    localparam logic [7:0]           COOL_T = 8'(COOLDOWN_FRAMES);
    localparam logic [LASER_R_W-1:0] R_TOP  = LASER_R_W'(R_MAX);

    laser_state_t          state_q, state_d;
    logic                  active_q, active_d;
    logic [LASER_R_W-1:0]  r_q, r_d;
    quadrant_t             quad_q, quad_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    quadrant_t             shot_quad_q, shot_quad_d;

    logic                  timer_clear_s;
    logic [7:0]            timer_target_s;
    logic                  timer_hit_s;

    // Every transition out of a timed state happens on a hit, which already
    // restarts the count, so only IDLE and abort need an explicit clear.
    always_comb begin
        timer_clear_s  = (state_q == IDLE) || abort;
        timer_target_s = 8'd1;
        case (state_q)
            EXTEND:   timer_target_s = STEP_T;
            HOLD:     timer_target_s = HOLD_T;
            COOLDOWN: timer_target_s = COOL_T;
            default:  timer_target_s = 8'd1;
        endcase
    end

    laser_frame_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .clear      (timer_clear_s),
        .target     (timer_target_s),
        .hit        (timer_hit_s)
    );

    // Next-state and output logic; abort overrides fire and frame_tick.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        r_d         = r_q;
        quad_d      = quad_q;
        done_d      = 1'b0;
        shot_quad_d = shot_quad_q;
        if (abort) begin
            state_d  = IDLE;
            active_d = 1'b0;
            r_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        quad_d   = aim_quadrant;
                        r_d      = '0;
                        active_d = 1'b1;
                        state_d  = EXTEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXTEND: begin
                    if (timer_hit_s) begin
                        r_d = r_q + 4'd1;
                        if ((r_q + 4'd1) == R_TOP) begin
                            state_d = HOLD;
                        end else begin
                            state_d = EXTEND;
                        end
                    end else begin
                        state_d = EXTEND;
                    end
                end
                HOLD: begin
                    if (timer_hit_s) begin
                        active_d    = 1'b0;
                        done_d      = 1'b1;
                        shot_quad_d = quad_q;
                        state_d     = COOLDOWN;
                    end else begin
                        state_d = HOLD;
                    end
                end
                COOLDOWN: begin
                    if (timer_hit_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = COOLDOWN;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                    r_d      = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            r_q         <= '0;
            quad_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shot_quad_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            r_q         <= r_d;
            quad_q      <= quad_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shot_quad_q <= shot_quad_d;
        end
    end

    assign laser_active   = active_q;
    assign laser_r        = r_q;
    assign laser_quadrant = quad_q;
    assign busy           = busy_q;
    assign shot_done      = done_q;
    assign shot_quadrant  = shot_quad_q;

endmodule

// File: tb/tb_laser_controller.sv
// Directed self-checking bench for laser_controller (default and minimum parameter sets).
module tb_laser_controller;

    logic       clk;
    logic       rst, frame_tick, fire, abort;
    logic [1:0] aim_quadrant;
    logic       laser_active, busy, shot_done;
    logic [3:0] laser_r;
    logic [1:0] laser_quadrant, shot_quadrant;

    logic       rst_b, frame_tick_b, fire_b, abort_b;
    logic [1:0] aim_b;
    logic       active_b, busy_b, done_b;
    logic [3:0] r_b;
    logic [1:0] quad_b, shot_quad_b;

    int checks = 0;
    int errors = 0;
    int sd_count = 0;

    laser_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
        .aim_quadrant(aim_quadrant), .abort(abort),
        .laser_active(laser_active), .laser_r(laser_r),
        .laser_quadrant(laser_quadrant), .busy(busy),
        .shot_done(shot_done), .shot_quadrant(shot_quadrant)
    );

    laser_controller #(
        .STEP_FRAMES(1), .HOLD_FRAMES(1), .COOLDOWN_FRAMES(1), .R_MAX(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .frame_tick(frame_tick_b), .fire(fire_b),
        .aim_quadrant(aim_b), .abort(abort_b),
        .laser_active(active_b), .laser_r(r_b),
        .laser_quadrant(quad_b), .busy(busy_b),
        .shot_done(done_b), .shot_quadrant(shot_quad_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (shot_done === 1'b1) sd_count <= sd_count + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic do_fire(input logic [1:0] q);
        fire = 1'b1;
        aim_quadrant = q;
        cyc();
        fire = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if ({laser_active, laser_r, laser_quadrant, busy, shot_done, shot_quadrant} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {laser_active, laser_r, laser_quadrant, busy, shot_done, shot_quadrant});
        end
    endtask

    task automatic test_basic();
        int sd0;
        sd0 = sd_count;
        do_fire(2'd2);
        checks++;
        if (laser_active !== 1'b1 || laser_quadrant !== 2'd2 || laser_r !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_fire got act=%b q=%0d r=%0d busy=%b expected 1 2 0 1", laser_active, laser_quadrant, laser_r, busy);
        end
        for (int t = 1; t <= 30; t++) begin
            do_tick();
            checks++;
            if (laser_r !== 4'(t / 2)) begin
                errors++;
                $display("FAIL basic_r tick %0d got %0d expected %0d", t, laser_r, t / 2);
            end
        end
        for (int t = 31; t <= 33; t++) begin
            do_tick();
            checks++;
            if (shot_done !== 1'b0 || laser_active !== 1'b1 || laser_r !== 4'd15) begin
                errors++;
                $display("FAIL basic_hold tick %0d got done=%b act=%b r=%0d expected 0 1 15", t, shot_done, laser_active, laser_r);
            end
        end
        do_tick();
        checks++;
        if (shot_done !== 1'b1 || shot_quadrant !== 2'd2 || laser_active !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b sq=%0d act=%b expected 1 2 0", shot_done, shot_quadrant, laser_active);
        end
        cyc();
        checks++;
        if (shot_done !== 1'b0 || shot_quadrant !== 2'd2 || laser_r !== 4'd15) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b sq=%0d r=%0d expected 0 2 15", shot_done, shot_quadrant, laser_r);
        end
        for (int t = 35; t <= 41; t++) begin
            do_tick();
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_cool tick %0d got busy=%b expected 1", t, busy);
            end
        end
        do_tick();
        checks++;
        if (busy !== 1'b0 || sd_count - sd0 !== 1) begin
            errors++;
            $display("FAIL basic_idle got busy=%b pulses=%0d expected 0 1", busy, sd_count - sd0);
        end
    endtask

    task automatic test_refire();
        do_fire(2'd0);
        for (int t = 1; t <= 42; t++) begin
            do_tick();
            if (t == 10 || t == 38) begin
                do_fire(2'd3);
                checks++;
                if (laser_quadrant !== 2'd0 || laser_r !== 4'(t == 10 ? 5 : 15) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL refire_ignored tick %0d got q=%0d r=%0d busy=%b expected 0 %0d 1", t, laser_quadrant, laser_r, busy, t == 10 ? 5 : 15);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL refire_busy got %b expected 0", busy);
        end
        do_fire(2'd1);
        checks++;
        if (laser_active !== 1'b1 || laser_quadrant !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL refire_accept got act=%b q=%0d busy=%b expected 1 1 1", laser_active, laser_quadrant, busy);
        end
        do_abort();
    endtask

    task automatic test_aim_change();
        do_fire(2'd1);
        for (int t = 1; t <= 34; t++) begin
            do_tick();
            if (t == 5) aim_quadrant = 2'd3;
        end
        checks++;
        if (laser_quadrant !== 2'd1 || shot_quadrant !== 2'd1 || shot_done !== 1'b1) begin
            errors++;
            $display("FAIL aim_change got q=%0d sq=%0d done=%b expected 1 1 1", laser_quadrant, shot_quadrant, shot_done);
        end
        for (int t = 35; t <= 42; t++) do_tick();
    endtask

    task automatic test_abort();
        int sd0;
        sd0 = sd_count;
        do_fire(2'd2);
        for (int t = 1; t <= 12; t++) do_tick();
        checks++;
        if (laser_r !== 4'd6) begin
            errors++;
            $display("FAIL abort_pre_r got %0d expected 6", laser_r);
        end
        abort = 1'b1;
        frame_tick = 1'b1;
        cyc();
        abort = 1'b0;
        frame_tick = 1'b0;
        checks++;
        if (laser_active !== 1'b0 || laser_r !== 4'd0 || busy !== 1'b0 || shot_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_kill got act=%b r=%0d busy=%b done=%b expected 0 0 0 0", laser_active, laser_r, busy, shot_done);
        end
        abort = 1'b1;
        do_fire(2'd3);
        abort = 1'b0;
        cyc();
        checks++;
        if (laser_active !== 1'b0 || busy !== 1'b0 || sd_count !== sd0) begin
            errors++;
            $display("FAIL abort_fire got act=%b busy=%b pulses=%0d expected 0 0 0", laser_active, busy, sd_count - sd0);
        end
    endtask

    task automatic test_fire_tick();
        frame_tick = 1'b1;
        do_fire(2'd0);
        frame_tick = 1'b0;
        do_tick();
        checks++;
        if (laser_r !== 4'd0) begin
            errors++;
            $display("FAIL fire_tick_r1 got %0d expected 0", laser_r);
        end
        do_tick();
        checks++;
        if (laser_r !== 4'd1) begin
            errors++;
            $display("FAIL fire_tick_r2 got %0d expected 1", laser_r);
        end
        do_abort();
    endtask

    task automatic tick_b();
        frame_tick_b = 1'b1;
        cyc();
        frame_tick_b = 1'b0;
    endtask

    task automatic test_boundary();
        rst_b = 1'b0;
        fire_b = 1'b1;
        aim_b = 2'd3;
        cyc();
        fire_b = 1'b0;
        tick_b();
        checks++;
        if (r_b !== 4'd1 || active_b !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL bnd_r got r=%0d act=%b busy=%b expected 1 1 1", r_b, active_b, busy_b);
        end
        tick_b();
        checks++;
        if (done_b !== 1'b1 || shot_quad_b !== 2'd3 || active_b !== 1'b0) begin
            errors++;
            $display("FAIL bnd_done got done=%b sq=%0d act=%b expected 1 3 0", done_b, shot_quad_b, active_b);
        end
        tick_b();
        checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL bnd_idle got busy=%b done=%b expected 0 0", busy_b, done_b);
        end
        fire_b = 1'b1;
        aim_b = 2'd2;
        cyc();
        fire_b = 1'b0;
        checks++;
        if (active_b !== 1'b1 || quad_b !== 2'd2) begin
            errors++;
            $display("FAIL bnd_refire got act=%b q=%0d expected 1 2", active_b, quad_b);
        end
        rst_b = 1'b1;
        abort_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        abort_b = 1'b0;
        checks++;
        if ({active_b, r_b, quad_b, busy_b, done_b, shot_quad_b} !== 11'd0) begin
            errors++;
            $display("FAIL bnd_reset got %b expected 0", {active_b, r_b, quad_b, busy_b, done_b, shot_quad_b});
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        fire = 1'b0;
        abort = 1'b0;
        aim_quadrant = 2'd0;
        rst_b = 1'b1;
        frame_tick_b = 1'b0;
        fire_b = 1'b0;
        abort_b = 1'b0;
        aim_b = 2'd0;
        test_reset();
        test_basic();
        test_refire();
        test_aim_change();
        test_abort();
        test_fire_tick();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
